// File: rtl/alu_operand_loader.sv
// ---------------------------------------------------------------------------
// alu_operand_loader
//
// Operand sequencer in front of the 8-bit ALU. A single debounced load button
// walks the user through entering operand A, operand B and the op select from
// shared switches. It then latches the ALU's combinational result for display.
//
// Optional feature (compile-time macro CHAIN_RESULT_EN):
//   defined     - a press in SHOW copies the displayed result into A and jumps
//                 straight to LOAD_B, so results chain into the next operation.
//   not defined - a press in SHOW returns to LOAD_A and leaves A unchanged.
//
// Ports
//   clk          in   1       clock, all logic on the rising edge
//   rst          in   1       synchronous active-high reset
//   sw_in        in   DATA_W  operand switches
//   sel_in       in   SEL_W   op select switches
//   btn_in       in   1       raw asynchronous load button, active-high
//   alu_y_in     in   8       ALU result (combinational from a/b/sel outputs)
//   a_out        out  8       registered operand A
//   b_out        out  8       registered operand B
//   sel_out      out  SEL_W   registered op select
//   result_out   out  8       latched ALU result
//   result_valid out  1       high while in SHOW (fresh result displayed)
//   state_out    out  3       FSM state (LOAD_A=0 .. SHOW=4)
// ---------------------------------------------------------------------------
module alu_operand_loader #(
  parameter int DATA_W       = 4,
  parameter int SEL_W        = 3,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw_in,
  input  logic [SEL_W-1:0]  sel_in,
  input  logic              btn_in,
  input  logic [7:0]        alu_y_in,
  output logic [7:0]        a_out,
  output logic [7:0]        b_out,
  output logic [SEL_W-1:0]  sel_out,
  output logic [7:0]        result_out,
  output logic              result_valid,
  output logic [2:0]        state_out
);

  // The counter only has to reach DEBOUNCE_CYC-1.
  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  // Button path registers
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             db_q, db_d;
  logic             db_prev_q, db_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press;

  // Sequencer registers
  state_t           state_q, state_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [7:0]       result_q, result_d;
  logic             valid_q, valid_d;

  // Synchroniser and debouncer. The counter measures how many consecutive
  // cycles the synchronised button has disagreed with the accepted level.
  // Any agreeing cycle clears it. A new level is accepted on the
  // DEBOUNCE_CYC-th disagreeing cycle.
  always_comb begin
    s1_d      = btn_in;
    s2_d      = s1_q;
    db_prev_d = db_q;
    db_d      = db_q;
    cnt_d     = '0;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // One-cycle pulse on an accepted rising edge only; releases are silent.
  assign press = db_q & ~db_prev_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    result_d = result_q;
    valid_d  = valid_q;
    unique case (state_q)
      LOAD_A: begin
        if (press) begin
          a_d     = 8'(sw_in);
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (press) begin
          b_d     = 8'(sw_in);
          state_d = LOAD_OP;
        end
      end
      LOAD_OP: begin
        if (press) begin
          sel_d   = sel_in;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // One cycle so the ALU sees the freshly registered select
        // before its output is captured. A press here is ignored.
        result_d = alu_y_in;
        valid_d  = 1'b1;
        state_d  = SHOW;
      end
      SHOW: begin
        if (press) begin
          valid_d = 1'b0;
`ifdef CHAIN_RESULT_EN
          a_d     = result_q;
          state_d = LOAD_B;
`else
          state_d = LOAD_A;
`endif
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
      state_q   <= LOAD_A;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sel_q     <= sel_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
    end
  end

  assign a_out        = a_q;
  assign b_out        = b_q;
  assign sel_out      = sel_q;
  assign result_out   = result_q;
  assign result_valid = valid_q;
  assign state_out    = state_q;

endmodule
